// File: rtl/reg_wb_sched.sv
// Register write-back scheduler: per-register write reservations, RAW/WAW issue stall,
// and round-robin arbitration of two write-back requesters onto one register-file port.
module reg_wb_sched #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned REGW  = 4,
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REGW-1:0]  issue_rs,
  input  logic [REGW-1:0]  issue_rt,
  input  logic [REGW-1:0]  issue_rd,
  input  logic             issue_wr,
  output logic             stall,
  input  logic             req0,
  input  logic             req1,
  input  logic [REGW-1:0]  regno0,
  input  logic [REGW-1:0]  regno1,
  input  logic [DATAW-1:0] data0,
  input  logic [DATAW-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             wb_en,
  output logic [REGW-1:0]  wb_regno,
  output logic [DATAW-1:0] wb_data,
  output logic [NREG-1:0]  w_reserve,
  output logic             err
);

  logic [NREG-1:0]  w_reserve_q, w_reserve_d;
  logic             wb_en_q, wb_en_d;
  logic [REGW-1:0]  wb_regno_q, wb_regno_d;
  logic [DATAW-1:0] wb_data_q, wb_data_d;
  logic             err_q, err_d;
  // High when unit 1 received the most recent contended or uncontended grant.
  logic             rr_last_q, rr_last_d;

  logic             any_gnt;
  logic             accept;
  logic [REGW-1:0]  g_regno;
  logic [DATAW-1:0] g_data;
  logic [NREG-1:0]  set_vec;
  logic [NREG-1:0]  clr_vec;

  always_comb begin
    gnt0    = req0 & (~req1 | rr_last_q);
    gnt1    = req1 & ~gnt0;
    any_gnt = gnt0 | gnt1;
    g_regno = gnt1 ? regno1 : regno0;
    g_data  = gnt1 ? data1 : data0;
  end

  // Stall looks only at the registered bitmap; a same-edge release unstalls next cycle.
  always_comb begin
    stall  = issue_valid & (w_reserve_q[issue_rs] | w_reserve_q[issue_rt] |
                            (issue_wr & w_reserve_q[issue_rd]));
    accept = issue_valid & ~stall;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && issue_wr) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (any_gnt) begin
      clr_vec[g_regno] = 1'b1;
    end
    // Set is applied after clear so a same-bit collision keeps the new reservation.
    w_reserve_d = (w_reserve_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    rr_last_d  = any_gnt ? gnt1 : rr_last_q;
    wb_en_d    = any_gnt;
    wb_regno_d = any_gnt ? g_regno : wb_regno_q;
    wb_data_d  = any_gnt ? g_data : wb_data_q;
    err_d      = err_q | (any_gnt & ~w_reserve_q[g_regno]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_reserve_q <= '0;
      wb_en_q     <= 1'b0;
      wb_regno_q  <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      w_reserve_q <= w_reserve_d;
      wb_en_q     <= wb_en_d;
      wb_regno_q  <= wb_regno_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_regno  = wb_regno_q;
  assign wb_data   = wb_data_q;
  assign w_reserve = w_reserve_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched: a cycle-by-cycle vector table followed by a hand-written
// fairness sequence with both requesters contending continuously.
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wr;
  logic [3:0]  issue_rs, issue_rt, issue_rd;
  logic        stall;
  logic        req0, req1;
  logic [3:0]  regno0, regno1;
  logic [31:0] data0, data1;
  logic        gnt0, gnt1;
  logic        wb_en;
  logic [3:0]  wb_regno;
  logic [31:0] wb_data;
  logic [15:0] w_reserve;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_sched #(.NREG(16), .REGW(4), .DATAW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rs   (issue_rs),
    .issue_rt   (issue_rt),
    .issue_rd   (issue_rd),
    .issue_wr   (issue_wr),
    .stall      (stall),
    .req0       (req0),
    .req1       (req1),
    .regno0     (regno0),
    .regno1     (regno1),
    .data0      (data0),
    .data1      (data1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .wb_en      (wb_en),
    .wb_regno   (wb_regno),
    .wb_data    (wb_data),
    .w_reserve  (w_reserve),
    .err        (err)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  rs, rt, rd;
    logic        wr;
    logic        r0;
    logic [3:0]  n0;
    logic [31:0] d0;
    logic        r1;
    logic [3:0]  n1;
    logic [31:0] d1;
    logic        cc;     // compare the combinational outputs this cycle
    logic        stall, g0, g1;
    logic        wben;
    logic [3:0]  regno;
    logic [31:0] data;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs_n, logic iv, int rs, int rt, int rd, logic wr,
                              logic r0, int n0, int unsigned d0,
                              logic r1, int n1, int unsigned d1,
                              logic cc, logic st, logic g0, logic g1,
                              logic wbe, int rno, int unsigned dat, int res, logic er);
    vec_t v;
    v.rst = rs_n; v.iv = iv; v.rs = 4'(rs); v.rt = 4'(rt); v.rd = 4'(rd); v.wr = wr;
    v.r0 = r0; v.n0 = 4'(n0); v.d0 = d0; v.r1 = r1; v.n1 = 4'(n1); v.d1 = d1;
    v.cc = cc; v.stall = st; v.g0 = g0; v.g1 = g1;
    v.wben = wbe; v.regno = 4'(rno); v.data = dat; v.res = 16'(res); v.err = er;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_wr = 1'b0;
    issue_rs = '0; issue_rt = '0; issue_rd = '0;
    req0 = 1'b0; req1 = 1'b0; regno0 = '0; regno1 = '0; data0 = '0; data1 = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    //          rst iv rs rt rd wr  r0 n0 d0           r1 n1 d1     cc st g0 g1  wbe rno data        res     err
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,          1, 0, 0,    0, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0,          1, 0, 0,    0, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    // contention on r1/r2
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0002, 0));
    vecs.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0006, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 'h11,       1, 2, 'h22, 1, 0, 1, 0,  1, 1, 'h11,       'h0004, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          1, 2, 'h22, 1, 0, 0, 1,  1, 2, 'h22,       'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    // RAW on r3
    vecs.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0008, 0));
    vecs.push_back(mk(1, 1, 3, 0, 4, 1, 1, 3, 'hDEADBEEF, 0, 0, 0,    1, 1, 1, 0,  1, 3, 'hDEADBEEF, 'h0000, 0));
    vecs.push_back(mk(1, 1, 3, 0, 4, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0010, 0));
    // WAW on r5
    vecs.push_back(mk(1, 1, 0, 0, 5, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0030, 0));
    vecs.push_back(mk(1, 1, 0, 0, 5, 1, 0, 0, 0,          0, 0, 0,    1, 1, 0, 0,  0, 0, 0,          'h0030, 0));
    vecs.push_back(mk(1, 1, 0, 0, 5, 1, 0, 0, 0,          1, 5, 'h55, 1, 1, 0, 1,  1, 5, 'h55,       'h0010, 0));
    vecs.push_back(mk(1, 1, 0, 0, 5, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0030, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4, 'h44,       1, 5, 'h55, 1, 0, 1, 0,  1, 4, 'h44,       'h0020, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          1, 5, 'h55, 1, 0, 0, 1,  1, 5, 'h55,       'h0000, 0));
    // write to unreserved r7: err is sticky until reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          1, 7, 'h77, 1, 0, 0, 1,  1, 7, 'h77,       'h0000, 1));
    vecs.push_back(mk(1, 1, 0, 0, 6, 1, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0040, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 6, 'h66,       0, 0, 0,    1, 0, 1, 0,  1, 6, 'h66,       'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    0, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    // set and clear of r9 at one edge: set wins, err flags the unreserved write
    vecs.push_back(mk(1, 1, 0, 0, 9, 1, 1, 9, 'h99,       0, 0, 0,    1, 0, 1, 0,  1, 9, 'h99,       'h0200, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 'h9A,       0, 0, 0,    1, 0, 1, 0,  1, 9, 'h9A,       'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    0, 0, 0, 0,  0, 0, 0,          'h0000, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0,    1, 0, 0, 0,  0, 0, 0,          'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      issue_valid = vecs[i].iv; issue_rs = vecs[i].rs; issue_rt = vecs[i].rt;
      issue_rd = vecs[i].rd; issue_wr = vecs[i].wr;
      req0 = vecs[i].r0; regno0 = vecs[i].n0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; regno1 = vecs[i].n1; data1 = vecs[i].d1;
      #1;
      if (vecs[i].cc) begin
        chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].stall));
        chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
        chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vecs[i].wben));
      chk($sformatf("v%0d w_reserve", i), 32'(w_reserve), 32'(vecs[i].res));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
      if (vecs[i].wben) begin
        chk($sformatf("v%0d wb_regno", i), 32'(wb_regno), 32'(vecs[i].regno));
        chk($sformatf("v%0d wb_data", i), 32'(wb_data), 32'(vecs[i].data));
      end
    end

    // Fairness: reserve r1..r8, then both units request continuously for 8 cycles.
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      idle_inputs();
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 4'(r);
    end
    @(posedge clk);
    #1;
    chk("fair reserve", 32'(w_reserve), 32'h01FE);
    begin
      int i0 = 0;
      int i1 = 0;
      for (int c = 0; c < 8; c++) begin
        logic       exp_g0;
        logic [3:0] exp_rno;
        @(negedge clk);
        idle_inputs();
        req0 = 1'b1; regno0 = 4'(1 + 2 * i0); data0 = 32'(1 + 2 * i0) * 32'h101;
        req1 = 1'b1; regno1 = 4'(2 + 2 * i1); data1 = 32'(2 + 2 * i1) * 32'h101;
        exp_g0  = (c % 2 == 0);
        exp_rno = exp_g0 ? regno0 : regno1;
        #1;
        chk($sformatf("fair c%0d gnt0", c), 32'(gnt0), 32'(exp_g0));
        chk($sformatf("fair c%0d gnt1", c), 32'(gnt1), 32'(!exp_g0));
        @(posedge clk);
        #1;
        chk($sformatf("fair c%0d wb_en", c), 32'(wb_en), 32'd1);
        chk($sformatf("fair c%0d wb_regno", c), 32'(wb_regno), 32'(exp_rno));
        chk($sformatf("fair c%0d wb_data", c), wb_data, 32'(exp_rno) * 32'h101);
        if (exp_g0) i0++;
        else i1++;
      end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("fair end reserve", 32'(w_reserve), 32'h0000);
    chk("fair end err", 32'(err), 32'd0);
    chk("fair end wb_en", 32'(wb_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
